// File: rtl/smg_scan_ctrl_if.sv
// smg_scan_ctrl_if
//   Display-value update channel for smg_scan_ctrl.
//   data_i    : 32-bit display value, sampled by the controller when upd_i=1
//   upd_i     : single-cycle update request
//   upd_ack_o : single-cycle pulse when the staged value reaches the shadow
//   master drives data_i/upd_i; slave (the controller) drives upd_ack_o.
interface smg_scan_ctrl_if;
   logic [31:0] data_i;
   logic        upd_i;
   logic        upd_ack_o;

   modport master (output data_i, output upd_i, input upd_ack_o);
   modport slave  (input data_i, input upd_i, output upd_ack_o);
endinterface

// File: rtl/smg_scan_ctrl.sv
// smg_scan_ctrl
//   Four-digit common-anode seven-segment scan controller. Shows one 16-bit
//   halfword of a double-buffered 32-bit value. It also generates the
//   periodic flag1s_o strobe.
//   Optional build macro SMG_LZ_BLANK_EN enables leading-zero blanking.
//   Without it, every digit shows its hex value.
// Ports
//   clk_i       : core clock
//   rst_i       : asynchronous active-high reset
//   upd_if      : update channel (data_i, upd_i, upd_ack_o), slave side
//   page_auto_i : 1 = page toggles on every flag1s_o pulse
//   half_sel_i  : page select when page_auto_i=0, taken at frame boundary
//   flag1s_o    : 1-cycle pulse every TICK_DIV cycles
//   seg_byte_o  : digit enables, active-low, bit n = nibble n
//   seg_bit_o   : segments {g,f,e,d,c,b,a}, active-low
//   dp_o        : decimal point, active-low, lit on digit 0 of high page
//
// Digit FSM
//   state | meaning
//   DIG0  | slot for nibble 0 (rightmost digit)
//   DIG1  | slot for nibble 1
//   DIG2  | slot for nibble 2
//   DIG3  | slot for nibble 3; its scan tick is the frame boundary
module smg_scan_ctrl #(
   parameter int CLK_HZ    = 25000000,
   parameter int SCAN_HZ   = 1000,
   parameter int TICK_HZ   = 1,
   parameter int GHOST_CYC = 16      // must be 1..SCAN_DIV-1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   smg_scan_ctrl_if.slave   upd_if,
   input  logic             page_auto_i,
   input  logic             half_sel_i,
   output logic             flag1s_o,
   output logic [3:0]       seg_byte_o,
   output logic [6:0]       seg_bit_o,
   output logic             dp_o
);

   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   // Down-counters: the reload value marks the first cycle of a period.
   // Zero is the terminal count.
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   // The first GHOST_CYC cycles of a slot are the top GHOST_CYC counter values.
   localparam logic [SCAN_W-1:0] GHOST_TH  = SCAN_W'(SCAN_DIV - GHOST_CYC);

   typedef enum logic [1:0] {DIG0 = 2'd0, DIG1 = 2'd1, DIG2 = 2'd2, DIG3 = 2'd3} digit_t;

   digit_t             digit, digit_nxt;
   logic [SCAN_W-1:0]  scan_cnt;
   logic [TICK_W-1:0]  tick_cnt;
   logic [31:0]        staging, shadow;
   logic               pending;
   logic               page;

   logic               scan_tc, tick_tc, frame_tc, ghost;
   logic [15:0]        half;
   logic [3:0]         nib;
   logic [6:0]         seg_nxt;

   assign scan_tc  = (scan_cnt == '0);
   assign tick_tc  = (tick_cnt == '0);
   assign frame_tc = scan_tc && (digit == DIG3);
   assign ghost    = (scan_cnt >= GHOST_TH);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) digit <= DIG0;
      else       digit <= digit_nxt;
   end

   always_comb begin
      digit_nxt = digit;
      if (scan_tc) begin
         case (digit)
            DIG0:    digit_nxt = DIG1;
            DIG1:    digit_nxt = DIG2;
            DIG2:    digit_nxt = DIG3;
            default: digit_nxt = DIG0;
         endcase
      end
   end

   always_comb begin
      half    = page ? shadow[31:16] : shadow[15:0];
      nib     = half[{digit, 2'b00} +: 4];
      seg_nxt = 7'h7F;
      case (nib)
         4'h0: seg_nxt = 7'h40;
         4'h1: seg_nxt = 7'h79;
         4'h2: seg_nxt = 7'h24;
         4'h3: seg_nxt = 7'h30;
         4'h4: seg_nxt = 7'h19;
         4'h5: seg_nxt = 7'h12;
         4'h6: seg_nxt = 7'h02;
         4'h7: seg_nxt = 7'h78;
         4'h8: seg_nxt = 7'h00;
         4'h9: seg_nxt = 7'h10;
         4'hA: seg_nxt = 7'h08;
         4'hB: seg_nxt = 7'h03;
         4'hC: seg_nxt = 7'h46;
         4'hD: seg_nxt = 7'h21;
         4'hE: seg_nxt = 7'h06;
         default: seg_nxt = 7'h0E;
      endcase
`ifdef SMG_LZ_BLANK_EN
      // Blank a digit when it and every digit to its left are zero.
      // Digit 0 is never blanked.
      case (digit)
         DIG3:    if (half[15:12] == 4'h0)  seg_nxt = 7'h7F;
         DIG2:    if (half[15:8]  == 8'h00) seg_nxt = 7'h7F;
         DIG1:    if (half[15:4]  == 12'h0) seg_nxt = 7'h7F;
         default: ;
      endcase
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tick_cnt         <= TICK_LAST;
         scan_cnt         <= SCAN_LAST;
         flag1s_o         <= 1'b0;
         staging          <= '0;
         shadow           <= '0;
         pending          <= 1'b0;
         page             <= 1'b0;
         upd_if.upd_ack_o <= 1'b0;
         seg_byte_o       <= 4'hF;
         seg_bit_o        <= 7'h7F;
         dp_o             <= 1'b1;
      end else begin
         tick_cnt <= tick_tc ? TICK_LAST : tick_cnt - 1'b1;
         scan_cnt <= scan_tc ? SCAN_LAST : scan_cnt - 1'b1;
         flag1s_o <= tick_tc;

         // A request in the same cycle as a load refills staging.
         // pending stays set, so the new value lands on the next frame.
         upd_if.upd_ack_o <= frame_tc && pending;
         if (frame_tc && pending) shadow <= staging;
         if (upd_if.upd_i) begin
            staging <= upd_if.data_i;
            pending <= 1'b1;
         end else if (frame_tc) begin
            pending <= 1'b0;
         end

         if (page_auto_i) begin
            if (flag1s_o) page <= ~page;
         end else if (frame_tc) begin
            page <= half_sel_i;
         end

         seg_byte_o <= ghost ? 4'hF : ~(4'b0001 << digit);
         seg_bit_o  <= seg_nxt;
         dp_o       <= ~((digit == DIG0) && page);
      end
   end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
module tb_smg_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       page_auto = 1'b0;
   logic       half_sel = 1'b0;
   logic       flag1s;
   logic [3:0] seg_byte;
   logic [6:0] seg_bit;
   logic       dp;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc;
   logic [6:0] hex_tab [16];

   smg_scan_ctrl_if upd_if ();

   smg_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100), .TICK_HZ(10), .GHOST_CYC(2)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .upd_if     (upd_if.slave),
      .page_auto_i(page_auto),
      .half_sel_i (half_sel),
      .flag1s_o   (flag1s),
      .seg_byte_o (seg_byte),
      .seg_bit_o  (seg_bit),
      .dp_o       (dp)
   );

   always #5 clk = ~clk;

   // Number of rising edges since reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Expected outputs after edge c. They reflect the state after edge c-1:
   // slot position (c-1)%10 and digit ((c-1)/10)%4.
   function automatic logic [3:0] exp_byte(int c);
      int p;
      p = c - 1;
      if (p % 10 < 2) return 4'hF;
      return ~(4'b0001 << ((p / 10) % 4));
   endfunction

   function automatic logic [6:0] exp_bit(logic [31:0] sh, logic pg, int c);
      int d;
      logic [15:0] h;
      logic [3:0] n;
      d = ((c - 1) / 10) % 4;
      h = pg ? sh[31:16] : sh[15:0];
      n = h[d*4 +: 4];
`ifdef SMG_LZ_BLANK_EN
      if (d > 0 && (h >> (d * 4)) == 16'h0) return 7'h7F;
`endif
      return hex_tab[n];
   endfunction

   function automatic logic exp_dp(logic pg, int c);
      return !((((c - 1) / 10) % 4 == 0) && pg);
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      upd_if.upd_i = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic pulse_upd(logic [31:0] d);
      upd_if.data_i = d;
      upd_if.upd_i  = 1'b1;
      tick();
      upd_if.upd_i  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_assert += 5;
      if (seg_byte !== 4'hF)         begin n_fail++; $display("FAIL rst_seg_byte got %h exp f", seg_byte); end
      if (seg_bit !== 7'h7F)         begin n_fail++; $display("FAIL rst_seg_bit got %h exp 7f", seg_bit); end
      if (dp !== 1'b1)               begin n_fail++; $display("FAIL rst_dp got %b exp 1", dp); end
      if (flag1s !== 1'b0)           begin n_fail++; $display("FAIL rst_flag1s got %b exp 0", flag1s); end
      if (upd_if.upd_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b exp 0", upd_if.upd_ack_o); end
      rst = 1'b0;
      while (cyc < 305) begin
         tick();
         n_assert++;
         if (flag1s !== (cyc % 100 == 0)) begin
            n_fail++;
            $display("FAIL flag1s c=%0d got %b exp %b", cyc, flag1s, (cyc % 100 == 0));
         end
      end
   endtask

   task automatic test_scan_digits();
      logic [31:0] sh;
      do_reset();
      page_auto = 1'b0;
      half_sel  = 1'b0;
      while (cyc < 3) tick();
      pulse_upd(32'h0000_1234);
      while (cyc < 120) begin
         tick();
         sh = (cyc - 1 >= 40) ? 32'h0000_1234 : 32'h0;
         n_assert += 4;
         if (seg_byte !== exp_byte(cyc))       begin n_fail++; $display("FAIL scan_byte c=%0d got %b exp %b", cyc, seg_byte, exp_byte(cyc)); end
         if (seg_bit !== exp_bit(sh, 0, cyc))  begin n_fail++; $display("FAIL scan_bit c=%0d got %h exp %h", cyc, seg_bit, exp_bit(sh, 0, cyc)); end
         if (dp !== 1'b1)                      begin n_fail++; $display("FAIL scan_dp c=%0d got %b exp 1", cyc, dp); end
         if (upd_if.upd_ack_o !== (cyc == 40)) begin n_fail++; $display("FAIL scan_ack c=%0d got %b exp %b", cyc, upd_if.upd_ack_o, (cyc == 40)); end
      end
   endtask

   task automatic test_page_auto();
      logic [31:0] sh;
      logic pg;
      do_reset();
      page_auto = 1'b1;
      while (cyc < 3) tick();
      pulse_upd(32'hABCD_0000);
      while (cyc < 260) begin
         tick();
         sh = (cyc - 1 >= 40) ? 32'hABCD_0000 : 32'h0;
         pg = (cyc >= 2) ? (((cyc - 2) / 100) % 2 == 1) : 1'b0;
         n_assert += 4;
         if (seg_byte !== exp_byte(cyc))       begin n_fail++; $display("FAIL page_byte c=%0d got %b exp %b", cyc, seg_byte, exp_byte(cyc)); end
         if (seg_bit !== exp_bit(sh, pg, cyc)) begin n_fail++; $display("FAIL page_bit c=%0d got %h exp %h", cyc, seg_bit, exp_bit(sh, pg, cyc)); end
         if (dp !== exp_dp(pg, cyc))           begin n_fail++; $display("FAIL page_dp c=%0d got %b exp %b", cyc, dp, exp_dp(pg, cyc)); end
         if (flag1s !== (cyc % 100 == 0))      begin n_fail++; $display("FAIL page_flag c=%0d got %b exp %b", cyc, flag1s, (cyc % 100 == 0)); end
      end
      page_auto = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] sh;
      int acks;
      do_reset();
      while (cyc < 5) tick();
      pulse_upd(32'h0000_5678);
      while (cyc < 39) tick();
      pulse_upd(32'h0000_9ABC);
      acks = 0;
      n_assert++;
      if (upd_if.upd_ack_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ack40 got %b exp 1", upd_if.upd_ack_o); end
      if (upd_if.upd_ack_o === 1'b1) acks++;
      while (cyc < 130) begin
         tick();
         if (upd_if.upd_ack_o === 1'b1) acks++;
         sh = (cyc - 1 >= 80) ? 32'h0000_9ABC : 32'h0000_5678;
         n_assert += 2;
         if (seg_bit !== exp_bit(sh, 0, cyc))  begin n_fail++; $display("FAIL b2b_bit c=%0d got %h exp %h", cyc, seg_bit, exp_bit(sh, 0, cyc)); end
         if (upd_if.upd_ack_o !== (cyc == 80)) begin n_fail++; $display("FAIL b2b_ack c=%0d got %b exp %b", cyc, upd_if.upd_ack_o, (cyc == 80)); end
      end
      n_assert++;
      if (acks !== 2) begin n_fail++; $display("FAIL b2b_ack_count got %0d exp 2", acks); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      while (cyc < 3) tick();
      pulse_upd(32'h0000_FFFF);
      while (cyc < 24) tick();
      #2 rst = 1'b1;
      #1;
      n_assert += 4;
      if (seg_byte !== 4'hF)         begin n_fail++; $display("FAIL mid_seg_byte got %h exp f", seg_byte); end
      if (seg_bit !== 7'h7F)         begin n_fail++; $display("FAIL mid_seg_bit got %h exp 7f", seg_bit); end
      if (dp !== 1'b1)               begin n_fail++; $display("FAIL mid_dp got %b exp 1", dp); end
      if (upd_if.upd_ack_o !== 1'b0) begin n_fail++; $display("FAIL mid_ack got %b exp 0", upd_if.upd_ack_o); end
      repeat (2) tick();
      rst = 1'b0;
      while (cyc < 100) begin
         tick();
         n_assert += 3;
         if (upd_if.upd_ack_o !== 1'b0)          begin n_fail++; $display("FAIL mid_post_ack c=%0d got %b exp 0", cyc, upd_if.upd_ack_o); end
         if (seg_bit !== exp_bit(32'h0, 0, cyc)) begin n_fail++; $display("FAIL mid_post_bit c=%0d got %h exp %h", cyc, seg_bit, exp_bit(32'h0, 0, cyc)); end
         if (seg_byte !== exp_byte(cyc))         begin n_fail++; $display("FAIL mid_post_byte c=%0d got %b exp %b", cyc, seg_byte, exp_byte(cyc)); end
      end
   endtask

   task automatic test_lz_blank();
      logic [31:0] sh;
      do_reset();
      while (cyc < 3) tick();
      pulse_upd(32'h0000_0003);
      while (cyc < 10) tick();
      pulse_upd(32'h0000_0005);
      while (cyc < 90) begin
         tick();
         sh = (cyc - 1 >= 40) ? 32'h0000_0005 : 32'h0;
         n_assert += 2;
         if (seg_bit !== exp_bit(sh, 0, cyc))  begin n_fail++; $display("FAIL lz_bit c=%0d got %h exp %h", cyc, seg_bit, exp_bit(sh, 0, cyc)); end
         if (upd_if.upd_ack_o !== (cyc == 40)) begin n_fail++; $display("FAIL lz_ack c=%0d got %b exp %b", cyc, upd_if.upd_ack_o, (cyc == 40)); end
      end
   endtask

   initial begin
      hex_tab[0]  = 7'h40; hex_tab[1]  = 7'h79; hex_tab[2]  = 7'h24; hex_tab[3]  = 7'h30;
      hex_tab[4]  = 7'h19; hex_tab[5]  = 7'h12; hex_tab[6]  = 7'h02; hex_tab[7]  = 7'h78;
      hex_tab[8]  = 7'h00; hex_tab[9]  = 7'h10; hex_tab[10] = 7'h08; hex_tab[11] = 7'h03;
      hex_tab[12] = 7'h46; hex_tab[13] = 7'h21; hex_tab[14] = 7'h06; hex_tab[15] = 7'h0E;
      upd_if.data_i = 32'h0;
      upd_if.upd_i  = 1'b0;
      test_reset();
      test_scan_digits();
      test_page_auto();
      test_back_to_back();
      test_reset_mid();
      test_lz_blank();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/smg_scan_ctrl.md
Name: smg_scan_ctrl

Overview:
Seven-segment display controller for the SoC top-level SMG outputs, clocked on the 25 MHz core clock.
- Time-multiplexes one 16-bit halfword of a 32-bit display value across 4 common-anode digits.
- Generates the 1 s strobe consumed by the core (flag1s).
- Double-buffers display data with a request/ack handshake so the value only changes on frame boundaries (no tearing).

Parameters:
CLK_HZ, 25000000, input clock frequency
SCAN_HZ, 1000, digit-slot rate; SCAN_DIV = CLK_HZ/SCAN_HZ cycles per digit slot
TICK_HZ, 1, flag1s_o rate; TICK_DIV = CLK_HZ/TICK_HZ cycles per tick
GHOST_CYC, 16, cycles at start of each digit slot with all digits off (must be < SCAN_DIV)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
data_i  in  32  display value, sampled when upd_i=1
upd_i  in  1  update request, single-cycle pulse
upd_ack_o  out  1  1-cycle pulse: staged value moved to shadow
page_auto_i  in  1  1: halfword page toggles on every flag1s_o tick
half_sel_i  in  1  page select when page_auto_i=0 (0 = [15:0], 1 = [31:16])
flag1s_o  out  1  1-cycle pulse every TICK_DIV cycles
seg_byte_o  out  4  digit enables, active-low; bit n = nibble n of the selected halfword
seg_bit_o  out  7  segments {g,f,e,d,c,b,a}, active-low
dp_o  out  1  decimal point, active-low

Behaviour:
- Reset values (asynchronous): seg_byte_o=4'b1111, seg_bit_o=7'h7F, dp_o=1, flag1s_o=0, upd_ack_o=0. Internal state: staging=0, shadow=0, pending=0, digit=0, page=0, all counters=0.
- Tick counter: 0..TICK_DIV-1. flag1s_o=1 for the cycle after the counter wraps from TICK_DIV-1. First pulse occurs TICK_DIV cycles after reset release.
- Scan counter: 0..SCAN_DIV-1. On wrap (scan tick), digit advances 0→1→2→3→0.
- Frame boundary: scan tick with digit==3.
- Update handshake:
  - upd_i=1: staging<=data_i, pending<=1.
  - At a frame boundary with pending=1: shadow<=staging, pending<=0, upd_ack_o pulses the next cycle.
  - upd_i coincident with a load: shadow takes the old staging value; staging takes the new data_i; pending stays 1. The new value loads at the next frame boundary.
  - Multiple upd_i between boundaries: last value wins; only one ack is issued.
- Page selection:
  - page_auto_i=1: page toggles on each flag1s_o cycle.
  - page_auto_i=0: page<=half_sel_i, registered, applied at the next frame boundary.
- Outputs are registered from the current digit, page and shadow:
  - nib = shadow[page*16 + digit*4 +: 4].
  - seg_byte_o = ~(1<<digit), except 4'b1111 while scan counter < GHOST_CYC.
  - seg_bit_o = hex(nib).
- Hex table (nibble 0..F): 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
- dp_o=0 only when digit==0 and page==1 (indicates the high halfword is shown); otherwise 1.
- Output latency: 1 cycle from a digit/counter change to the output change.
- Reset mid-frame: all state returns to reset values immediately. Any pending update is discarded and no ack is issued.

Optional Feature:
SMG_LZ_BLANK_EN
- Defined: leading-zero blanking. Digit n (n=3..1) outputs seg_bit_o=7'h7F when nibbles n..3 of the displayed halfword are all zero. Digit 0 always shows, so value 0 displays a single "0". Digit enable and dp_o timing are unchanged.
- Undefined: all four digits always display their hex value, including leading zeros.

Test Plan:
Bench parameters: CLK_HZ=1000, SCAN_HZ=100 (SCAN_DIV=10), TICK_HZ=10 (TICK_DIV=100), GHOST_CYC=2.
1. Reset held, then released: outputs at reset values. flag1s_o first pulses 100 cycles after release, then every 100 cycles thereafter.
2. upd_i with data_i=32'h0000_1234, page_auto_i=0, half_sel_i=0: upd_ack_o pulses once after the next digit-3 scan tick. Then per digit slot: digit 0 → seg_byte_o=1110, seg_bit_o=19; digit 1 → 1101, 30; digit 2 → 1011, 24; digit 3 → 0111, 79. seg_byte_o=1111 for the first 2 cycles of each slot.
3. Shadow=32'hABCD_0000, page_auto_i=1: page flips on each flag1s_o. On high page, digit 0 shows seg_bit_o=21 with dp_o=0. On low page, digit 0 shows 40 with dp_o=1.
4. upd_i asserted in the same cycle as a frame-boundary load: the old staged value is displayed, the new value appears one frame later, and exactly two acks are seen in total.
5. Assert rst_i mid-slot with pending=1: outputs return to reset values within the cycle, no ack is issued, and shadow=0 after release.
6. With SMG_LZ_BLANK_EN defined, shadow low half = 16'h0005: digits 3..1 show 7F and digit 0 shows 12. Without the macro: digits 3..1 show 40.
